// File: rtl/cp0_timer_irq.sv
// CP0 subset: SR/Cause/EPC/PRId plus an optional Count/Compare timer.
// Handler entry is combinational (Req). The timer keeps running no matter what EXL, Req or IE are.
module cp0_timer_irq #(
    parameter int          NUM_HWINT = 6,
    parameter int          TIMER_EN  = 1,
    parameter int          COUNT_DIV = 2,
    parameter logic [31:0] PRID      = 32'h0000_0001
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           addr,
    input  logic                 WE,
    input  logic [31:0]          WD,
    input  logic [31:0]          pc,
    input  logic                 isBD,
    input  logic [4:0]           ExcCode,
    input  logic [NUM_HWINT-1:0] HWInt,
    input  logic                 EXLClr,
    output logic [31:0]          RD,
    output logic                 Req,
    output logic [31:0]          EPCOUT,
    output logic                 TimerIrq
);
    localparam logic [4:0] A_COUNT = 5'd9,  A_COMPARE = 5'd11, A_SR   = 5'd12;
    localparam logic [4:0] A_CAUSE = 5'd13, A_EPC     = 5'd14, A_PRID = 5'd15;
    localparam logic [3:0] PMAX    = 4'(COUNT_DIV - 1);
    localparam logic       TEN     = 1'(TIMER_EN != 0);

    logic [NUM_HWINT-1:0] im_hw_q, im_hw_d, ip_hw_q;
    logic                 im_t_q, im_t_d, exl_q, exl_d, ie_q, ie_d;
    logic                 bd_q, bd_d, ti_q, ti_d, ip_t_q;
    logic [4:0]           exc_q, exc_d;
    logic [31:0]          epc_q, epc_d, count_q, count_d, compare_q, compare_d;
    logic [3:0]           presc_q, presc_d;
    logic                 int_req, wr_en, cnt_wr, cmp_wr, inc;
    logic [31:0]          count_inc, sr_v, cause_v;

    assign int_req   = ie_q & ((|(HWInt & im_hw_q)) | (TEN & ti_q & im_t_q));
    assign Req       = ~exl_q & ((ExcCode != 5'd0) | int_req);
    assign wr_en     = WE & ~Req & ~EXLClr;
    assign cnt_wr    = wr_en & (addr == A_COUNT);
    assign cmp_wr    = wr_en & (addr == A_COMPARE);
    assign inc       = (presc_q == PMAX) & ~cnt_wr;
    assign count_inc = count_q + 32'd1;
    assign EPCOUT    = epc_q;
    assign TimerIrq  = TEN & ti_q;

    always_comb begin
        im_hw_d   = im_hw_q;
        im_t_d    = im_t_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        exc_d     = exc_q;
        epc_d     = epc_q;
        count_d   = count_q;
        compare_d = compare_q;
        presc_d   = presc_q;
        ti_d      = ti_q;
        if (Req) begin
            exl_d = 1'b1;
            bd_d  = isBD;
            epc_d = isBD ? pc - 32'd4 : pc;
            // A pending interrupt takes precedence over a simultaneous exception.
            exc_d = int_req ? 5'd0 : ExcCode;
        end else if (EXLClr) begin
            exl_d = 1'b0;
        end else if (WE) begin
            case (addr)
                A_SR: begin
                    im_hw_d = WD[10 +: NUM_HWINT];
                    im_t_d  = TEN & WD[16];
                    exl_d   = WD[1];
                    ie_d    = WD[0];
                end
                A_EPC:   epc_d = {WD[31:2], 2'b00};
                default: ;
            endcase
        end
        if (TEN) begin
            if (cnt_wr) begin
                count_d = WD;
                presc_d = 4'd0;
            end else if (inc) begin
                count_d = count_inc;
                presc_d = 4'd0;
            end else begin
                presc_d = presc_q + 4'd1;
            end
            // Only an increment landing on Compare raises TI; a Compare write always clears it.
            if (cmp_wr) begin
                compare_d = WD;
                ti_d      = 1'b0;
            end else if (inc && count_inc == compare_q) begin
                ti_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            im_hw_q   <= '0;
            im_t_q    <= 1'b0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ti_q      <= 1'b0;
            ip_hw_q   <= '0;
            ip_t_q    <= 1'b0;
            exc_q     <= 5'd0;
            epc_q     <= 32'd0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            presc_q   <= 4'd0;
        end else begin
            im_hw_q   <= im_hw_d;
            im_t_q    <= im_t_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ti_q      <= ti_d;
            ip_hw_q   <= HWInt;
            ip_t_q    <= ti_q;
            exc_q     <= exc_d;
            epc_q     <= epc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            presc_q   <= presc_d;
        end
    end

    always_comb begin
        sr_v                    = 32'd0;
        sr_v[10 +: NUM_HWINT]   = im_hw_q;
        sr_v[16]                = TEN & im_t_q;
        sr_v[1]                 = exl_q;
        sr_v[0]                 = ie_q;
        cause_v                 = 32'd0;
        cause_v[31]             = bd_q;
        cause_v[30]             = TEN & ti_q;
        cause_v[10 +: NUM_HWINT] = ip_hw_q;
        cause_v[16]             = TEN & ip_t_q;
        cause_v[6:2]            = exc_q;
        RD                      = 32'd0;
        case (addr)
            A_COUNT:   RD = TEN ? count_q : 32'd0;
            A_COMPARE: RD = TEN ? compare_q : 32'd0;
            A_SR:      RD = sr_v;
            A_CAUSE:   RD = cause_v;
            A_EPC:     RD = epc_q;
            A_PRID:    RD = PRID;
            default:   RD = 32'd0;
        endcase
    end
endmodule
